// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state codes,
// the opcode values it decodes and the wait-counter width.
package multicycle_ctrl_fsm_pkg;

    // Phase codes; 7..15 are unused and recover to ST_IF.
    typedef enum logic [3:0] {
        ST_IF    = 4'd0,
        ST_ID    = 4'd1,
        ST_EX    = 4'd2,
        ST_EX_BR = 4'd3,
        ST_MEM   = 4'd4,
        ST_WB    = 4'd5,
        ST_HALT  = 4'd6
    } state_e;

    // RV32I major opcodes, inst[6:0].
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Wide enough for wait limits up to 15 cycles.
    localparam int CNT_W = 4;

    // Jumps write the ALU target into the PC at writeback.
    function automatic logic is_jump(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_wait_counter.sv
// Wait-cycle counter: counts up to a limit and holds there; clear has
// priority over enable. done flags the final cycle of a wait phase.
module multicycle_ctrl_fsm_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done = (cnt_q == limit);
    assign cnt  = cnt_q;

    // Next count: clear on phase exit, advance while enabled and not at limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !done) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM of the multi-cycle RV32I core: phase register, per-cycle
// datapath strobes, stall freeze, illegal-opcode recovery and a
// retired-instruction counter.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int IF_CYCLES     = 2,
    parameter int MEM_CYCLES    = 1,
    parameter int RET_W         = 32,
    parameter bit HALT_ON_ECALL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             halt_cond,
    input  logic             stall,
    output logic [3:0]       state,
    output logic             imem_read,
    output logic             ir_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             reg_write,
    output logic             pc_update,
    output logic             pc_src,
    output logic             illegal,
    output logic             is_halted,
    output logic [RET_W-1:0] retire_cnt
);

    localparam logic [CNT_W-1:0] IF_LAST  = CNT_W'(IF_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_CYCLES - 1);

    state_e             state_q, state_d;
    logic               started_q;
    logic [RET_W-1:0]   retire_q, retire_d;
    logic [CNT_W-1:0]   cnt_limit;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_done;
    logic               leave;
    logic               frozen;

    // Stall freezes everything except HALT, which is absorbing anyway.
    assign frozen = stall && (state_q != ST_HALT);

    // Terminal count for the current wait phase; single-cycle phases use 0.
    always_comb begin
        cnt_limit = '0;
        case (state_q)
            ST_IF:   cnt_limit = IF_LAST;
            ST_MEM:  cnt_limit = MEM_LAST;
            default: cnt_limit = '0;
        endcase
    end

    multicycle_ctrl_fsm_wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (leave),
        .en    (started_q && !frozen),
        .limit (cnt_limit),
        .cnt   (cnt),
        .done  (cnt_done)
    );

    // Next-state and strobe decode; leave marks any taken transition,
    // including the IF->IF re-entry of a non-halting ECALL.
    always_comb begin
        state_d    = state_q;
        leave      = 1'b0;
        imem_read  = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        is_halted  = 1'b0;
        if (started_q) begin
            case (state_q)
                ST_IF: begin
                    imem_read = 1'b1;
                    if (cnt_done) begin
                        ir_write = 1'b1;
                        leave    = 1'b1;
                        if (opcode == OPC_SYSTEM) begin
                            if (halt_cond && HALT_ON_ECALL) begin
                                state_d = ST_HALT;
                            end else begin
                                state_d   = ST_IF;
                                pc_update = 1'b1;
                            end
                        end else if (opcode == OPC_JAL) begin
                            state_d = ST_EX;
                        end else begin
                            state_d = ST_ID;
                        end
                    end
                end
                ST_ID: begin
                    leave   = 1'b1;
                    state_d = ST_EX;
                end
                ST_EX: begin
                    leave = 1'b1;
                    case (opcode)
                        OPC_BRANCH: begin
                            if (alu_bcond) begin
                                state_d = ST_EX_BR;
                            end else begin
                                state_d   = ST_IF;
                                pc_update = 1'b1;
                            end
                        end
                        OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR: state_d = ST_WB;
                        OPC_LOAD, OPC_STORE:                   state_d = ST_MEM;
                        default: begin
                            state_d   = ST_IF;
                            pc_update = 1'b1;
                            illegal   = 1'b1;
                        end
                    endcase
                end
                ST_EX_BR: begin
                    leave     = 1'b1;
                    state_d   = ST_IF;
                    pc_update = 1'b1;
                    pc_src    = 1'b1;
                end
                ST_MEM: begin
                    dmem_read = (opcode == OPC_LOAD);
                    if (cnt_done) begin
                        leave = 1'b1;
                        if (opcode == OPC_STORE) begin
                            dmem_write = 1'b1;
                            pc_update  = 1'b1;
                            state_d    = ST_IF;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    leave     = 1'b1;
                    reg_write = 1'b1;
                    pc_update = 1'b1;
                    pc_src    = is_jump(opcode);
                    state_d   = ST_IF;
                end
                ST_HALT: begin
                    is_halted = 1'b1;
                    state_d   = ST_HALT;
                end
                default: begin
                    leave   = 1'b1;
                    state_d = ST_IF;
                end
            endcase

            if (frozen) begin
                state_d    = state_q;
                leave      = 1'b0;
                ir_write   = 1'b0;
                dmem_write = 1'b0;
                reg_write  = 1'b0;
                pc_update  = 1'b0;
                illegal    = 1'b0;
            end
        end
    end

    // Retire counter wraps naturally at 2^RET_W.
    always_comb begin
        retire_d = retire_q + RET_W'(pc_update);
    end

    // State, start flag and retire counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IF;
            started_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            retire_q  <= retire_d;
        end
    end

    assign state      = state_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. dut_a uses the default timing
// (IF=2, MEM=1, RET_W=32); dut_b uses IF=1, MEM=4, RET_W=4.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b0000000;

    logic clk;
    logic rst_a, rst_b;

    logic [6:0] op_a, op_b;
    logic       bc_a, bc_b, hc_a, hc_b, stall_a, stall_b;
    logic [3:0] state_a, state_b;
    logic       imem_a, irw_a, dr_a, dw_a, rw_a, pcu_a, src_a, ill_a, halt_a;
    logic       imem_b, irw_b, dr_b, dw_b, rw_b, pcu_b, src_b, ill_b, halt_b;
    logic [31:0] ret_a;
    logic [3:0]  ret_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut_a (
        .clk(clk), .reset_n(rst_a), .opcode(op_a), .alu_bcond(bc_a),
        .halt_cond(hc_a), .stall(stall_a), .state(state_a),
        .imem_read(imem_a), .ir_write(irw_a), .dmem_read(dr_a),
        .dmem_write(dw_a), .reg_write(rw_a), .pc_update(pcu_a),
        .pc_src(src_a), .illegal(ill_a), .is_halted(halt_a),
        .retire_cnt(ret_a)
    );

    multicycle_ctrl_fsm #(
        .IF_CYCLES(1), .MEM_CYCLES(4), .RET_W(4), .HALT_ON_ECALL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(rst_b), .opcode(op_b), .alu_bcond(bc_b),
        .halt_cond(hc_b), .stall(stall_b), .state(state_b),
        .imem_read(imem_b), .ir_write(irw_b), .dmem_read(dr_b),
        .dmem_write(dw_b), .reg_write(rw_b), .pc_update(pcu_b),
        .pc_src(src_b), .illegal(ill_b), .is_halted(halt_b),
        .retire_cnt(ret_b)
    );

    // Strobe vector: {imem, ir_write, dmem_read, dmem_write, reg_write, pc_update, pc_src, illegal}
    function automatic logic [7:0] outs_a();
        return {imem_a, irw_a, dr_a, dw_a, rw_a, pcu_a, src_a, ill_a};
    endfunction

    function automatic logic [7:0] outs_b();
        return {imem_b, irw_b, dr_b, dw_b, rw_b, pcu_b, src_b, ill_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply one cycle of inputs (called just after a rising edge),
    // check state and strobes, then advance to just after the next edge.
    task automatic cyc_a(input string tag, input logic [6:0] op, input logic bc,
                         input logic hc, input logic stl,
                         input logic [3:0] st, input logic [7:0] strb);
        op_a = op; bc_a = bc; hc_a = hc; stall_a = stl;
        #1;
        check({tag, "_state"}, 32'(state_a), 32'(st));
        check({tag, "_outs"}, 32'(outs_a()), 32'(strb));
        @(posedge clk); #1;
    endtask

    task automatic cyc_b(input string tag, input logic [6:0] op, input logic hc,
                         input logic stl, input logic [3:0] st, input logic [7:0] strb);
        op_b = op; bc_b = 1'b0; hc_b = hc; stall_b = stl;
        #1;
        check({tag, "_state"}, 32'(state_b), 32'(st));
        check({tag, "_outs"}, 32'(outs_b()), 32'(strb));
        @(posedge clk); #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        op_a = OP_ALU; op_b = OP_ALU;
        bc_a = 1'b0; bc_b = 1'b0; hc_a = 1'b0; hc_b = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_state", 32'(state_a), 32'd0);
        check("rst_a_outs", 32'(outs_a()), 32'd0);
        check("rst_a_ret", ret_a, 32'd0);
        check("rst_b_outs", 32'({outs_b(), halt_b}), 32'd0);

        // ---------------- dut_a: default timing ----------------
        rst_a = 1'b1;
        #1;
        check("a_prestart_outs", 32'(outs_a()), 32'd0);
        @(posedge clk); #1;

        // ADD: IF,IF,ID,EX,WB
        cyc_a("add_if0", OP_ALU, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("add_if1", OP_ALU, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("add_id",  OP_ALU, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("add_ex",  OP_ALU, 0, 0, 0, 4'd2, 8'h00);
        cyc_a("add_wb",  OP_ALU, 0, 0, 0, 4'd5, 8'h0C);
        // LW: IF,IF,ID,EX,MEM,WB
        cyc_a("lw_if0", OP_LOAD, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("lw_if1", OP_LOAD, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("lw_id",  OP_LOAD, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("lw_ex",  OP_LOAD, 0, 0, 0, 4'd2, 8'h00);
        cyc_a("lw_mem", OP_LOAD, 0, 0, 0, 4'd4, 8'h20);
        cyc_a("lw_wb",  OP_LOAD, 0, 0, 0, 4'd5, 8'h0C);
        // SW: IF,IF,ID,EX,MEM
        cyc_a("sw_if0", OP_STORE, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("sw_if1", OP_STORE, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("sw_id",  OP_STORE, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("sw_ex",  OP_STORE, 0, 0, 0, 4'd2, 8'h00);
        cyc_a("sw_mem", OP_STORE, 0, 0, 0, 4'd4, 8'h14);
        check("ret_after_16", ret_a, 32'd3);

        // BEQ taken: 5 cycles, pc_src=1 in EX_BR
        cyc_a("bt_if0", OP_BRANCH, 1, 0, 0, 4'd0, 8'h80);
        cyc_a("bt_if1", OP_BRANCH, 1, 0, 0, 4'd0, 8'hC0);
        cyc_a("bt_id",  OP_BRANCH, 1, 0, 0, 4'd1, 8'h00);
        cyc_a("bt_ex",  OP_BRANCH, 1, 0, 0, 4'd2, 8'h00);
        cyc_a("bt_exbr", OP_BRANCH, 1, 0, 0, 4'd3, 8'h06);
        check("ret_bt", ret_a, 32'd4);
        // BEQ not taken: 4 cycles, pc_src=0
        cyc_a("bn_if0", OP_BRANCH, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("bn_if1", OP_BRANCH, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("bn_id",  OP_BRANCH, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("bn_ex",  OP_BRANCH, 0, 0, 0, 4'd2, 8'h04);
        check("ret_bn", ret_a, 32'd5);
        // JAL: IF,IF,EX,WB with pc_src=1
        cyc_a("jal_if0", OP_JAL, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("jal_if1", OP_JAL, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("jal_ex",  OP_JAL, 0, 0, 0, 4'd2, 8'h00);
        cyc_a("jal_wb",  OP_JAL, 0, 0, 0, 4'd5, 8'h0E);
        // Illegal opcode: illegal pulse in EX, retires, back to IF
        cyc_a("ill_if0", OP_BAD, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("ill_if1", OP_BAD, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("ill_id",  OP_BAD, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("ill_ex",  OP_BAD, 0, 0, 0, 4'd2, 8'h05);
        check("ret_ill", ret_a, 32'd7);
        check("ill_next_state", 32'(state_a), 32'd0);
        // ADD stalled on final IF cycle: ir_write deferred one cycle
        cyc_a("st_if0",  OP_ALU, 0, 0, 0, 4'd0, 8'h80);
        cyc_a("st_if1s", OP_ALU, 0, 0, 1, 4'd0, 8'h80);
        cyc_a("st_if1",  OP_ALU, 0, 0, 0, 4'd0, 8'hC0);
        cyc_a("st_id",   OP_ALU, 0, 0, 0, 4'd1, 8'h00);
        cyc_a("st_ex",   OP_ALU, 0, 0, 0, 4'd2, 8'h00);
        cyc_a("st_wb",   OP_ALU, 0, 0, 0, 4'd5, 8'h0C);
        check("ret_st", ret_a, 32'd8);
        // Halting ECALL: HALT after 2 cycles, no retire
        cyc_a("ec_if0", OP_ECALL, 0, 1, 0, 4'd0, 8'h80);
        cyc_a("ec_if1", OP_ECALL, 0, 1, 0, 4'd0, 8'hC0);
        for (int i = 0; i < 4; i++) begin
            cyc_a("halt_a", OP_ALU, 0, 1, i[0], 4'd6, 8'h00);
            check("halt_a_flag", 32'(halt_a), 32'd1);
        end
        check("ret_halt_a", ret_a, 32'd8);

        // ---------------- dut_b: IF=1, MEM=4, RET_W=4 ----------------
        rst_b = 1'b1;
        @(posedge clk); #1;
        // STORE, then reset while MEM cnt=1
        cyc_b("bsw_if",   OP_STORE, 0, 0, 4'd0, 8'hC0);
        cyc_b("bsw_id",   OP_STORE, 0, 0, 4'd1, 8'h00);
        cyc_b("bsw_ex",   OP_STORE, 0, 0, 4'd2, 8'h00);
        cyc_b("bsw_mem0", OP_STORE, 0, 0, 4'd4, 8'h00);
        rst_b = 1'b0;
        #1;
        check("brst_state", 32'(state_b), 32'd0);
        check("brst_ret", 32'(ret_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("brst_outs", 32'({outs_b(), halt_b}), 32'd0);
            @(posedge clk); #1;
        end
        rst_b = 1'b1;
        #1;
        check("b_prestart_outs", 32'(outs_b()), 32'd0);
        @(posedge clk); #1;

        // LW with 2 stall cycles on the final MEM cycle: MEM lasts 6 cycles
        cyc_b("blw_if",   OP_LOAD, 0, 0, 4'd0, 8'hC0);
        cyc_b("blw_id",   OP_LOAD, 0, 0, 4'd1, 8'h00);
        cyc_b("blw_ex",   OP_LOAD, 0, 0, 4'd2, 8'h00);
        cyc_b("blw_mem0", OP_LOAD, 0, 0, 4'd4, 8'h20);
        cyc_b("blw_mem1", OP_LOAD, 0, 0, 4'd4, 8'h20);
        cyc_b("blw_mem2", OP_LOAD, 0, 0, 4'd4, 8'h20);
        cyc_b("blw_mem3s", OP_LOAD, 0, 1, 4'd4, 8'h20);
        cyc_b("blw_mem3s", OP_LOAD, 0, 1, 4'd4, 8'h20);
        cyc_b("blw_mem3", OP_LOAD, 0, 0, 4'd4, 8'h20);
        cyc_b("blw_wb",   OP_LOAD, 0, 0, 4'd5, 8'h0C);
        check("bret_lw", 32'(ret_b), 32'd1);

        // Non-halting ECALLs retire every cycle; 4-bit counter wraps at the 16th retire
        for (int k = 2; k <= 16; k++) begin
            exp_q.push_back(32'(k % 16));
            cyc_b("becall", OP_ECALL, 0, 0, 4'd0, 8'hC4);
            check("bret_wrap", 32'(ret_b), exp_q.pop_front());
        end
        // Halting ECALL, then HALT holds with stall toggling
        cyc_b("bec_halt", OP_ECALL, 1, 0, 4'd0, 8'hC0);
        for (int i = 0; i < 6; i++) begin
            cyc_b("bhalt", OP_ECALL, 1, i[0], 4'd6, 8'h00);
            check("bhalt_flag", 32'(halt_b), 32'd1);
        end
        check("bret_halt", 32'(ret_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
